pixel_probe: RTL
================

// Module: pixel_probe
// PURPOSE
//  Parametrised video debug probe: after a line/frame sync, skips DELAY valid pixels, then captures
//  up to DEPTH consecutive pixels into a buffer readable over Wishbone. Successor to single-pixel capture:
//  one clock domain, arm/abort control, burst capture, status/fill count. Sits on the peripheral bus beside the video pipe.
// PARAMETERS
//  DW       32  pixel/data width (<=32; read data zero-extended to 32)
//  LGDEPTH  4   log2 capture depth; DEPTH = 2**LGDEPTH words
//  DLYW     24  width of delay counter / CTRL delay field
// PORTS
//  i_clk        in   1          system clock (bus and pixel data)
//  i_reset_n    in   1          asynchronous active-low reset
//  i_wb_cyc     in   1          Wishbone cycle
//  i_wb_stb     in   1          Wishbone strobe
//  i_wb_we      in   1          write enable
//  i_wb_addr    in   LGDEPTH+1  word address; MSB=1 buffer, MSB=0 registers (addr[1:0])
//  i_wb_data    in   32         write data
//  o_wb_ack     out  1          ack, one cycle after stb
//  o_wb_stall   out  1          constant 0
//  o_wb_data    out  32         read data, registered
//  i_sync       in   1          line/frame start strobe
//  i_valid      in   1          pixel valid strobe
//  i_pixel      in   DW         pixel data
// BEHAVIOUR
//  Reset: state IDLE, delay=0, count=0, o_wb_ack=0, o_wb_data=0; buffer contents undefined.
//  Bus: o_wb_ack <= i_wb_stb&&i_wb_cyc; o_wb_data valid same cycle as ack. Stall always 0.
//  Register map (addr MSB=0): 0 CTRL: [DLYW-1:0] delay, [31] arm. Read: delay, [31]=busy(ARMED|DELAY|CAPTURE).
//   1 STATUS: [2:0] state, [8+LGDEPTH:8] fill count (0..DEPTH). 2 SUM (see CONFIGURATION). 3 reads 0.
//   Addr MSB=1: buffer word addr[LGDEPTH-1:0], zero-extended; writes ignored. Reads never disturb state.
//  FSM: IDLE -> (CTRL write, arm=1) ARMED; any state -> (CTRL write, arm=0) IDLE, count kept.
//   CTRL write arm=1 in any state: latch delay, count<=0, skip<=0, -> ARMED (restart).
//   ARMED -> (i_sync) DELAY, or directly CAPTURE when delay==0.
//   Pixel index 0 = a valid pixel coincident with i_sync, else first valid after it.
//   DELAY: each i_valid increments skip; on skip reaching delay next valid pixel is captured (CAPTURE).
//   CAPTURE: each i_valid writes i_pixel to buf[count], count++; count==DEPTH -> DONE.
//   i_sync during DELAY: ignored. i_sync during CAPTURE: -> DONE with partial count; a pixel valid
//    in that same cycle is NOT captured. DONE holds until next CTRL write.
//  Captures pixels with indices delay..delay+DEPTH-1 exactly; skip counter never wraps (delay<2**DLYW).
//  Simultaneous CTRL write and pixel event: CTRL write wins; pixel dropped.
//  Other register writes (addr 1..3, buffer) ignored. Reset mid-capture: immediate IDLE, count=0.
//  State codes: IDLE=0 ARMED=1 DELAY=2 CAPTURE=3 DONE=4.
// CONFIGURATION
//  PIXEL_PROBE_SUM_EN defined: 32-bit modulo-2**32 sum of all captured pixels, cleared on arm,
//   updated same cycle as buffer write; readable at reg 2.
//  Not defined: no accumulator logic; reg 2 reads 0.
// STRUCTURE
//  Package pixel_probe_pkg: state enum/codes, register indices (CTRL/STATUS/SUM), CTRL arm bit position.
//  Sub-module pixel_probe_buf: DEPTH x DW simple dual-port RAM, one write port (capture),
//   one registered read port (bus); read latency 1 cycle aligned with o_wb_ack.
// TESTING
//  1 Reset, read CTRL/STATUS -> 0x0 / 0x0; ack exactly 1 cycle after each stb; stall never high.
//  2 DEPTH=16, arm delay=3, sync then 20 valid pixels 0x100..0x113 -> DONE, count=16, buf[0]=0x103, buf[15]=0x112.
//  3 delay=0, sync coincident with valid 0xAA -> buf[0]=0xAA; gapped i_valid (every 3rd clk) still fills in order.
//  4 arm delay=2, 5 pixels captured then i_sync -> STATUS state=4, count=5; pixel on sync cycle not in buffer.
//  5 Mid-CAPTURE CTRL write arm=0 -> IDLE, count frozen; re-arm -> count=0, state=1; async reset mid-DELAY -> IDLE.
//  6 PIXEL_PROBE_SUM_EN: capture 0xFFFFFFFF,0x2 -> SUM=0x1 (wrap); without macro reg 2 reads 0.

Source files
------------

// File: rtl/pixel_probe_pkg.sv
// Shared types and register map for the pixel_probe video debug probe.
// Holds the FSM state codes, register indices and the CTRL arm bit position.
package pixel_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_SUM    = 2'd2;

    localparam int CTRL_ARM_BIT = 31;

    function automatic logic is_busy(input state_t s);
        return (s == ST_ARMED) || (s == ST_DELAY) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/pixel_probe_buf.sv
// Capture buffer: DEPTH x DW simple dual-port RAM with one write port and one registered read port.
// Contents are not reset; the read data updates only when re is high.
module pixel_probe_buf
    import pixel_probe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LGDEPTH = 4
) (
    input  logic               i_clk,
    input  logic               we,
    input  logic [LGDEPTH-1:0] waddr,
    input  logic [DW-1:0]      wdata,
    input  logic               re,
    input  logic [LGDEPTH-1:0] raddr,
    output logic [DW-1:0]      rdata
);

    logic [DW-1:0] mem [0:(2**LGDEPTH)-1];

    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_probe.sv
// Video debug probe: after i_sync skips a programmable number of valid pixels, then captures a burst
// into a Wishbone-readable buffer. Optional pixel sum at reg 2 when PIXEL_PROBE_SUM_EN is defined.
//
// state   | meaning
// IDLE    | not armed, buffer and count frozen
// ARMED   | waiting for i_sync
// DELAY   | counting down skipped valid pixels
// CAPTURE | writing valid pixels into the buffer
// DONE    | buffer full or cut short by i_sync; holds until next CTRL write
module pixel_probe
    import pixel_probe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LGDEPTH = 4,
    parameter int DLYW    = 24
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [LGDEPTH:0]   i_wb_addr,
    input  logic [31:0]        i_wb_data,
    output logic               o_wb_ack,
    output logic               o_wb_stall,
    output logic [31:0]        o_wb_data,
    input  logic               i_sync,
    input  logic               i_valid,
    input  logic [DW-1:0]      i_pixel
);

    localparam int DEPTH = 2**LGDEPTH;
    localparam logic [LGDEPTH:0] CNT_LAST = (LGDEPTH+1)'(DEPTH-1);
    localparam logic [DLYW-1:0]  DLY_ONE  = DLYW'(1);

    state_t            state, state_nxt;
    logic [DLYW-1:0]   delay_q, delay_nxt;
    logic [DLYW-1:0]   remain, remain_nxt;
    logic [LGDEPTH:0]  count, count_nxt;
    logic              cap_we;
    logic              arm_clr;
    logic              bus_req;
    logic              ctrl_wr;
    logic              rd_is_buf;
    logic [31:0]       reg_rdata;
    logic [31:0]       reg_rd;
    logic [31:0]       sum_rd;
    logic [DW-1:0]     buf_rdata;
    logic [31:0]       buf_word;
    logic [31:0]       pix_word;
    logic              unused_wdata;

    assign bus_req    = i_wb_cyc && i_wb_stb;
    assign ctrl_wr    = bus_req && i_wb_we && !i_wb_addr[LGDEPTH] && (i_wb_addr[1:0] == REG_CTRL);
    assign o_wb_stall = 1'b0;
    assign unused_wdata = ^i_wb_data;

    always_comb begin
        pix_word = '0;
        pix_word[DW-1:0] = i_pixel;
    end

    // A CTRL write always wins over a pixel event in the same cycle.
    always_comb begin
        state_nxt  = state;
        delay_nxt  = delay_q;
        remain_nxt = remain;
        count_nxt  = count;
        cap_we     = 1'b0;
        arm_clr    = 1'b0;
        if (ctrl_wr) begin
            if (i_wb_data[CTRL_ARM_BIT]) begin
                delay_nxt = i_wb_data[DLYW-1:0];
                count_nxt = '0;
                arm_clr   = 1'b1;
                state_nxt = ST_ARMED;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            case (state)
                ST_ARMED: if (i_sync) begin
                    if (delay_q == '0) begin
                        state_nxt = ST_CAPTURE;
                        if (i_valid) begin
                            cap_we    = 1'b1;
                            count_nxt = count + 1'b1;
                        end
                    end else if (i_valid && delay_q == DLY_ONE) begin
                        state_nxt = ST_CAPTURE;
                    end else begin
                        state_nxt  = ST_DELAY;
                        remain_nxt = i_valid ? delay_q - 1'b1 : delay_q;
                    end
                end
                ST_DELAY: if (i_valid) begin
                    remain_nxt = remain - 1'b1;
                    if (remain == DLY_ONE) state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (i_sync) begin
                        state_nxt = ST_DONE;
                    end else if (i_valid) begin
                        cap_we    = 1'b1;
                        count_nxt = count + 1'b1;
                        if (count == CNT_LAST) state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            delay_q <= '0;
            remain  <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            delay_q <= delay_nxt;
            remain  <= remain_nxt;
            count   <= count_nxt;
        end
    end

`ifdef PIXEL_PROBE_SUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)  sum_q <= '0;
        else if (arm_clr) sum_q <= '0;
        else if (cap_we)  sum_q <= sum_q + pix_word;
    end

    assign sum_rd = sum_q;
`else
    assign sum_rd = '0;
`endif

    always_comb begin
        reg_rd = '0;
        case (i_wb_addr[1:0])
            REG_CTRL: begin
                reg_rd[DLYW-1:0]     = delay_q;
                reg_rd[CTRL_ARM_BIT] = is_busy(state);
            end
            REG_STATUS: begin
                reg_rd[2:0]           = state;
                reg_rd[8+LGDEPTH:8]   = count;
            end
            REG_SUM: reg_rd = sum_rd;
            default: reg_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            rd_is_buf <= 1'b0;
            reg_rdata <= '0;
        end else begin
            o_wb_ack <= bus_req;
            if (bus_req) begin
                rd_is_buf <= i_wb_addr[LGDEPTH];
                reg_rdata <= reg_rd;
            end
        end
    end

    pixel_probe_buf #(
        .DW      (DW),
        .LGDEPTH (LGDEPTH)
    ) u_buf (
        .i_clk (i_clk),
        .we    (cap_we),
        .waddr (count[LGDEPTH-1:0]),
        .wdata (i_pixel),
        .re    (bus_req && i_wb_addr[LGDEPTH]),
        .raddr (i_wb_addr[LGDEPTH-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        buf_word = '0;
        buf_word[DW-1:0] = buf_rdata;
    end

    assign o_wb_data = rd_is_buf ? buf_word : reg_rdata;

endmodule
